fod_phe_cal: RTL and testbench

- Receive-side counterpart of the FOD digital controller. It consumes the 8-phase sampler word captured on each FDTC edge and decodes it into a phase index.
- It compares that index against the phase the controller expected to produce. From the signed error it runs a sign-sign LMS loop that adapts the DTC gain word (KDTC) fed back to the controller.
- It also flags sampler bubbles and reports loop lock. It sits in the FDTC clock domain beside the FOD controller.

---
 rtl/fod_pkg.sv | 22 ++
 rtl/fod_therm_dec.sv | 25 ++
 rtl/fod_phe_cal.sv | 137 +++++++++++++
 tb/tb_fod_phe_cal.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fod_pkg.sv
// Types and constants shared between the FOD controller and its receive-side
// phase calibration blocks.
package fod_pkg;

    localparam int unsigned FOD_WF = 16;
    localparam int unsigned FOD_WK = 10;

    typedef logic [2:0]        phe_t;
    typedef logic signed [2:0] phe_err_t;
    typedef logic signed [1:0] sgn_t;

    localparam sgn_t SGN_NEG  = 2'sb11;
    localparam sgn_t SGN_ZERO = 2'sb00;
    localparam sgn_t SGN_POS  = 2'sb01;

    function automatic sgn_t err_sign(input phe_err_t e);
        if (e == 3'sb000) return SGN_ZERO;
        else if (e[2])    return SGN_NEG;
        else              return SGN_POS;
    endfunction

endpackage

// File: rtl/fod_therm_dec.sv
// Combinational decoder for an 8-phase circular sampler word: reports the
// position of the single 1->0 edge, or flags the word as a bubble.
module fod_therm_dec
    import fod_pkg::*;
(
    input  logic [7:0] psamp,
    output phe_t       idx,
    output logic       valid
);

    logic [3:0] n_edges;

    always_comb begin
        idx     = '0;
        n_edges = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (psamp[k] && !psamp[(k + 1) % 8]) begin
                idx     = phe_t'(k);
                n_edges = n_edges + 4'd1;
            end
        end
        valid = (n_edges == 4'd1);
    end

endmodule

// File: rtl/fod_phe_cal.sv
// Decodes the FDTC-edge sampler word into a phase error and adapts the DTC gain
// with a windowed sign-sign LMS loop; also reports sampler bubbles and lock.
module fod_phe_cal
    import fod_pkg::*;
#(
    parameter int unsigned WF       = FOD_WF,
    parameter int unsigned WK       = FOD_WK,
    parameter int unsigned KDTC_RST = 512,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned LOCK_CNT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [7:0]    PSAMP,
    input  logic          PSAMP_VLD,
    input  logic [2:0]    EXP_PH,
    input  logic [WF-1:0] PHASE_FRAC,
    output logic [2:0]    PHE_OUT,
    output logic [2:0]    PHE_ERR,
    output logic          PHE_VLD,
    output logic          BUBBLE_ERR,
    output logic [WK-1:0] KDTC,
    output logic          LOCK
);

    localparam int unsigned AW = AVG_LOG2 + 2;
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);

    phe_t            dec_idx;
    logic            dec_valid;
    phe_t            phe_out_r;
    phe_err_t        phe_err_r;
    logic            phe_vld_r;
    logic            bubble_r;
    logic            frac_msb_r;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] acc_next;
    logic [AVG_LOG2-1:0]  win_cnt_r;
    logic [WK-1:0]   kdtc_r;
    logic [LW-1:0]   lock_cnt_r;
    logic [LW-1:0]   lock_cnt_next;
    logic            lock_r;
    logic            sample_ok;
    logic            err_small;
    sgn_t            s_e;
    sgn_t            prod;
    logic            frac_unused;

    // Only the residue sign steers the LMS update.
    assign frac_unused = ^PHASE_FRAC[WF-2:0];

    fod_therm_dec u_dec (
        .psamp (PSAMP),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            phe_out_r  <= '0;
            phe_err_r  <= '0;
            phe_vld_r  <= 1'b0;
            bubble_r   <= 1'b0;
            frac_msb_r <= 1'b0;
        end else begin
            phe_vld_r <= PSAMP_VLD;
            bubble_r  <= PSAMP_VLD && !dec_valid;
            if (PSAMP_VLD && dec_valid) begin
                phe_out_r <= dec_idx;
                phe_err_r <= phe_err_t'(dec_idx - EXP_PH);
            end
            if (PSAMP_VLD) frac_msb_r <= PHASE_FRAC[WF-1];
        end
    end

    assign sample_ok = phe_vld_r && !bubble_r;
    assign err_small = (phe_err_r == 3'sb000) || (phe_err_r == 3'sb001) ||
                       (phe_err_r == 3'sb111);

    always_comb begin
        s_e  = err_sign(phe_err_r);
        prod = SGN_ZERO;
        if (s_e != SGN_ZERO) prod = frac_msb_r ? s_e : sgn_t'(-s_e);
        acc_next = acc_r + {{(AW-2){prod[1]}}, prod};
    end

    // The window's last sample is folded into acc_next and applied to KDTC on
    // the same edge, so the step is visible two cycles after that sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r     <= '0;
            win_cnt_r <= '0;
            kdtc_r    <= WK'(KDTC_RST);
        end else if (sample_ok && EN) begin
            if (win_cnt_r == '1) begin
                acc_r     <= '0;
                win_cnt_r <= '0;
                if (!acc_next[AW-1] && acc_next != '0 && kdtc_r != '1)
                    kdtc_r <= kdtc_r + WK'(1);
                else if (acc_next[AW-1] && kdtc_r != '0)
                    kdtc_r <= kdtc_r - WK'(1);
            end else begin
                acc_r     <= acc_next;
                win_cnt_r <= win_cnt_r + AVG_LOG2'(1);
            end
        end
    end

    always_comb begin
        lock_cnt_next = lock_cnt_r;
        if (phe_vld_r) begin
            if (bubble_r || !err_small)
                lock_cnt_next = '0;
            else if (lock_cnt_r != LW'(LOCK_CNT))
                lock_cnt_next = lock_cnt_r + LW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_cnt_r <= '0;
            lock_r     <= 1'b0;
        end else begin
            lock_cnt_r <= lock_cnt_next;
            lock_r     <= (lock_cnt_next == LW'(LOCK_CNT));
        end
    end

    assign PHE_OUT    = phe_out_r;
    assign PHE_ERR    = phe_err_r;
    assign PHE_VLD    = phe_vld_r;
    assign BUBBLE_ERR = bubble_r;
    assign KDTC       = kdtc_r;
    assign LOCK       = lock_r;

endmodule

// File: tb/tb_fod_phe_cal.sv
// Directed bench for fod_phe_cal: decode sweep, bubbles, LMS steps,
// saturation, lock and mid-window reset.
module tb_fod_phe_cal;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  psamp;
    logic        psamp_vld;
    logic [2:0]  exp_ph;
    logic [15:0] phase_frac;

    logic [2:0] phe_out, phe_err, hi_out, hi_err, lo_out, lo_err;
    logic       phe_vld, bubble_err, lock;
    logic       hi_vld, hi_bub, hi_lock, lo_vld, lo_bub, lo_lock;
    logic [9:0] kdtc, hi_kdtc, lo_kdtc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fod_phe_cal u_dut (
        .CLK(clk), .RST(rst), .EN(en), .PSAMP(psamp), .PSAMP_VLD(psamp_vld),
        .EXP_PH(exp_ph), .PHASE_FRAC(phase_frac), .PHE_OUT(phe_out),
        .PHE_ERR(phe_err), .PHE_VLD(phe_vld), .BUBBLE_ERR(bubble_err),
        .KDTC(kdtc), .LOCK(lock)
    );

    fod_phe_cal #(.KDTC_RST(1023)) u_hi (
        .CLK(clk), .RST(rst), .EN(en), .PSAMP(psamp), .PSAMP_VLD(psamp_vld),
        .EXP_PH(exp_ph), .PHASE_FRAC(phase_frac), .PHE_OUT(hi_out),
        .PHE_ERR(hi_err), .PHE_VLD(hi_vld), .BUBBLE_ERR(hi_bub),
        .KDTC(hi_kdtc), .LOCK(hi_lock)
    );

    fod_phe_cal #(.KDTC_RST(0)) u_lo (
        .CLK(clk), .RST(rst), .EN(en), .PSAMP(psamp), .PSAMP_VLD(psamp_vld),
        .EXP_PH(exp_ph), .PHASE_FRAC(phase_frac), .PHE_OUT(lo_out),
        .PHE_ERR(lo_err), .PHE_VLD(lo_vld), .BUBBLE_ERR(lo_bub),
        .KDTC(lo_kdtc), .LOCK(lo_lock)
    );

    task automatic drive(input logic [7:0] p, input logic [2:0] e, input logic msb);
        @(negedge clk);
        psamp      = p;
        exp_ph     = e;
        phase_frac = {msb, 15'h1234};
        psamp_vld  = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        psamp_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        psamp_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (phe_out !== 3'd0) begin n_bad++; $display("FAIL rst_phe_out: got %0d want 0", phe_out); end
        n_cmp++; if (phe_err !== 3'd0) begin n_bad++; $display("FAIL rst_phe_err: got %0d want 0", phe_err); end
        n_cmp++; if (phe_vld !== 1'b0) begin n_bad++; $display("FAIL rst_phe_vld: got %b want 0", phe_vld); end
        n_cmp++; if (bubble_err !== 1'b0) begin n_bad++; $display("FAIL rst_bubble: got %b want 0", bubble_err); end
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL rst_kdtc: got %0d want 512", kdtc); end
        n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b want 0", lock); end
        n_cmp++; if (hi_kdtc !== 10'd1023) begin n_bad++; $display("FAIL rst_hi_kdtc: got %0d want 1023", hi_kdtc); end
        n_cmp++; if (lo_kdtc !== 10'd0) begin n_bad++; $display("FAIL rst_lo_kdtc: got %0d want 0", lo_kdtc); end
    endtask

    task automatic test_sweep();
        logic [2:0] want_o [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        logic [2:0] want_e [8] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010};
        logic [7:0] base;
        logic [7:0] pat;
        do_reset();
        base = 8'h0F;
        for (int r = 0; r < 8; r++) begin
            pat = (base << r) | (base >> (8 - r));
            drive(pat, 3'd0, 1'b1);
            idle();
            n_cmp++; if (phe_vld !== 1'b1 || bubble_err !== 1'b0) begin n_bad++; $display("FAIL sweep_vld[%0d]: vld=%b bub=%b want 1/0", r, phe_vld, bubble_err); end
            n_cmp++; if (phe_out !== want_o[r]) begin n_bad++; $display("FAIL sweep_out[%0d]: got %0d want %0d", r, phe_out, want_o[r]); end
            n_cmp++; if (phe_err !== want_e[r]) begin n_bad++; $display("FAIL sweep_err[%0d]: got %b want %b", r, phe_err, want_e[r]); end
        end
        idle();
        n_cmp++; if (phe_vld !== 1'b0) begin n_bad++; $display("FAIL sweep_vld_drop: got %b want 0", phe_vld); end
        drive(8'b0000_0001, 3'd5, 1'b0);
        idle();
        n_cmp++; if (phe_out !== 3'd0 || phe_err !== 3'b011) begin n_bad++; $display("FAIL dec_bit0: out=%0d err=%b want 0/011", phe_out, phe_err); end
        drive(8'b1000_0000, 3'd5, 1'b0);
        idle();
        n_cmp++; if (phe_out !== 3'd7 || phe_err !== 3'b010) begin n_bad++; $display("FAIL dec_bit7: out=%0d err=%b want 7/010", phe_out, phe_err); end
    endtask

    task automatic test_bubble();
        logic [7:0] bub [3] = '{8'h00, 8'hFF, 8'h55};
        do_reset();
        for (int i = 0; i < 15; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        n_cmp++; if (phe_out !== 3'd1) begin n_bad++; $display("FAIL bub_pre_out: got %0d want 1", phe_out); end
        for (int i = 0; i < 3; i++) begin
            drive(bub[i], 3'd0, 1'b0);
            idle();
            n_cmp++; if (bubble_err !== 1'b1 || phe_vld !== 1'b1) begin n_bad++; $display("FAIL bub_flag[%0d]: bub=%b vld=%b want 1/1", i, bubble_err, phe_vld); end
            n_cmp++; if (phe_out !== 3'd1 || phe_err !== 3'b001) begin n_bad++; $display("FAIL bub_hold[%0d]: out=%0d err=%b want 1/001", i, phe_out, phe_err); end
        end
        idle();
        n_cmp++; if (bubble_err !== 1'b0) begin n_bad++; $display("FAIL bub_clear: got %b want 0", bubble_err); end
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL bub_kdtc_hold: got %0d want 512", kdtc); end
        drive(8'h03, 3'd0, 1'b1);
        idle();
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL bub_kdtc_early: got %0d want 512", kdtc); end
        idle();
        n_cmp++; if (kdtc !== 10'd513) begin n_bad++; $display("FAIL bub_kdtc_step: got %0d want 513", kdtc); end
        for (int i = 0; i < 48; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        idle();
        n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL bub_lock_cleared: got %b want 0", lock); end
        n_cmp++; if (kdtc !== 10'd516) begin n_bad++; $display("FAIL bub_kdtc_final: got %0d want 516", kdtc); end
    endtask

    task automatic test_lms();
        do_reset();
        for (int i = 0; i < 16; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL lms_up_early: got %0d want 512", kdtc); end
        idle();
        n_cmp++; if (kdtc !== 10'd513) begin n_bad++; $display("FAIL lms_up: got %0d want 513", kdtc); end
        do_reset();
        for (int i = 0; i < 16; i++) drive(8'h03, 3'd0, 1'b0);
        idle();
        idle();
        n_cmp++; if (kdtc !== 10'd511) begin n_bad++; $display("FAIL lms_down: got %0d want 511", kdtc); end
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 16; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        idle();
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL lms_en_off: got %0d want 512", kdtc); end
        en = 1'b1;
        for (int i = 0; i < 16; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        idle();
        n_cmp++; if (kdtc !== 10'd513) begin n_bad++; $display("FAIL lms_en_on: got %0d want 513", kdtc); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 32; i++) drive(8'h03, 3'd0, 1'b0);
        idle();
        idle();
        n_cmp++; if (lo_kdtc !== 10'd0) begin n_bad++; $display("FAIL sat_lo: got %0d want 0", lo_kdtc); end
        n_cmp++; if (hi_kdtc !== 10'd1021) begin n_bad++; $display("FAIL sat_hi_down: got %0d want 1021", hi_kdtc); end
        do_reset();
        for (int i = 0; i < 32; i++) drive(8'h03, 3'd0, 1'b1);
        idle();
        idle();
        n_cmp++; if (hi_kdtc !== 10'd1023) begin n_bad++; $display("FAIL sat_hi: got %0d want 1023", hi_kdtc); end
        n_cmp++; if (lo_kdtc !== 10'd2) begin n_bad++; $display("FAIL sat_lo_up: got %0d want 2", lo_kdtc); end
    endtask

    task automatic test_lock();
        logic [7:0] pats [3] = '{8'h01, 8'h03, 8'h80};
        do_reset();
        for (int i = 0; i < 64; i++) drive(pats[i % 3], 3'd0, 1'b1);
        idle();
        n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL lock_63: got %b want 0", lock); end
        idle();
        n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL lock_64: got %b want 1", lock); end
        for (int i = 0; i < 6; i++) drive(8'h01, 3'd0, 1'b1);
        idle();
        idle();
        n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL lock_sat: got %b want 1", lock); end
        drive(8'h07, 3'd0, 1'b1);
        idle();
        n_cmp++; if (phe_err !== 3'b010 || lock !== 1'b1) begin n_bad++; $display("FAIL lock_err2_vld: err=%b lock=%b want 010/1", phe_err, lock); end
        idle();
        n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b want 0", lock); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) drive(8'h03, 3'd0, 1'b0);
        idle();
        n_cmp++; if (phe_out !== 3'd1) begin n_bad++; $display("FAIL midrst_pre: got %0d want 1", phe_out); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (phe_out !== 3'd0 || phe_err !== 3'd0 || phe_vld !== 1'b0 || bubble_err !== 1'b0) begin n_bad++; $display("FAIL midrst_outs: out=%0d err=%0d vld=%b bub=%b want 0/0/0/0", phe_out, phe_err, phe_vld, bubble_err); end
        n_cmp++; if (kdtc !== 10'd512 || lock !== 1'b0) begin n_bad++; $display("FAIL midrst_kdtc: kdtc=%0d lock=%b want 512/0", kdtc, lock); end
        drive(8'h03, 3'd0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            drive(8'h01, 3'd0, 1'b1);
            if (i == 11) begin
                n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL midrst_no_early: got %0d want 512", kdtc); end
            end
        end
        idle();
        n_cmp++; if (kdtc !== 10'd512) begin n_bad++; $display("FAIL midrst_pre_step: got %0d want 512", kdtc); end
        idle();
        n_cmp++; if (kdtc !== 10'd513) begin n_bad++; $display("FAIL midrst_step: got %0d want 513", kdtc); end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        psamp      = 8'h00;
        psamp_vld  = 1'b0;
        exp_ph     = 3'd0;
        phase_frac = '0;
        test_reset();
        test_sweep();
        test_bubble();
        test_lms();
        test_saturate();
        test_lock();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
